// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: PC ownership, redirects, stall/flush, HALT latch.
// Optional perf counters (perf_fetched/perf_stall/perf_squash) enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [1:0]         pc_sel,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    reg_target,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [PC_W-1:0]    if_id_link,
    output logic               if_id_valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall,
    output logic [15:0]        perf_squash
`endif
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc, pc_nx, ipc_nx;
    logic [INSTR_W-1:0] instr_nx;
    logic               valid_nx;
    logic [PC_W-1:0]    sext, rel_target, target;
    logic               redirect, halt_op;

    assign sext       = {{(PC_W-8){if_id_instr[7]}}, if_id_instr[7:0]};
    assign rel_target = if_id_pc + PC_W'(1) + sext;
    assign target     = (pc_sel == 2'b10) ? reg_target : rel_target;
    assign redirect   = if_id_valid & (((pc_sel == 2'b01) & branch_taken) |
                                       (pc_sel == 2'b11) | (pc_sel == 2'b10));
    assign halt_op    = if_id_valid & (if_id_instr[INSTR_W-1 -: 3] == 3'b111);

    assign imem_addr  = pc;
    assign if_id_link = if_id_pc + PC_W'(1);
    assign halted     = (state == HALT);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = if_id_instr;
        ipc_nx   = if_id_pc;
        valid_nx = if_id_valid;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (stall) begin
                    state_nx = RUN;
                end else if (redirect) begin
                    pc_nx    = target;
                    instr_nx = '0;
                    valid_nx = 1'b0;
                end else if (halt_op) begin
                    // HALT entry still advances PC once; the fetched word is discarded.
                    state_nx = HALT;
                    pc_nx    = pc + PC_W'(1);
                    instr_nx = '0;
                    valid_nx = 1'b0;
                end else if (flush) begin
                    pc_nx    = pc + PC_W'(1);
                    instr_nx = '0;
                    valid_nx = 1'b0;
                end else begin
                    pc_nx    = pc + PC_W'(1);
                    instr_nx = imem_rdata;
                    ipc_nx   = pc;
                    valid_nx = 1'b1;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            if_id_instr <= instr_nx;
            if_id_pc    <= ipc_nx;
            if_id_valid <= valid_nx;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_ev, stall_ev, squash_ev;

    assign stall_ev  = (state == RUN) & stall;
    assign squash_ev = (state == RUN) & ~stall & (redirect | flush);
    assign fetch_ev  = (state == RUN) & ~stall & ~redirect & ~halt_op & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_squash  <= '0;
        end else begin
            if (fetch_ev && perf_fetched != '1) perf_fetched <= perf_fetched + 16'd1;
            if (stall_ev && perf_stall != '1)   perf_stall   <= perf_stall + 16'd1;
            if (squash_ev && perf_squash != '1) perf_squash  <= perf_squash + 16'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage and IF/ID pipeline register for the 16-bit, 3-bit-opcode pipelined core. It owns the PC, drives the instruction-memory address, and presents `{instr, pc, valid}` to the decode and hazard logic. It applies redirects selected by decode's `pc_sel`, stalls and flushes requested by the hazard unit, and latches HALT (opcode 3'b111) so the core stops fetching.

Parameters:
PC_W, 9, PC and instruction-memory address width in words
RESET_PC, 0, PC value loaded at reset
INSTR_W, 16, instruction width; opcode is `instr[15:13]`, op is `instr[12:11]`

Ports:
clk  input  1  core clock, all state rising-edge
rst_n  input  1  asynchronous active-low reset
imem_addr  output  PC_W  instruction-memory word address, equals PC
imem_rdata  input  INSTR_W  combinational read data for imem_addr
stall  input  1  hazard unit hold: PC and IF/ID keep value
flush  input  1  squash: IF/ID loaded with bubble next edge
pc_sel  input  2  from decode: 00 seq, 01 PC-rel branch, 10 register target, 11 PC-rel with link
branch_taken  input  1  condition result for pc_sel=01; ignored for other encodings
reg_target  input  PC_W  register-sourced target (BX/BLX), valid when pc_sel=10
if_id_instr  output  INSTR_W  instruction presented to decode
if_id_pc  output  PC_W  address of if_id_instr
if_id_link  output  PC_W  `if_id_pc + 1` (mod 2^PC_W), link value for BL/BLX writeback
if_id_valid  output  1  1 = real instruction, 0 = bubble
halted  output  1  HALT latched

Behaviour:
- Reset (async, `rst_n` low): `PC = RESET_PC`, `if_id_instr = 0`, `if_id_pc = 0`, `if_id_valid = 0`, `halted = 0`, FSM = BOOT. Perf counters, if present, are 0.
- Bubble encoding is `instr = 16'h0000`, `valid = 0`. Decode treats opcode 000 as a no-op with all control signals 0.
- Redirect target:
  - `sext = {{(PC_W-8){instr[7]}}, instr[7:0]}` taken from `if_id_instr`.
  - `rel_target = if_id_pc + 1 + sext`, truncated to PC_W (wraps).
- Redirect condition:
  - `redirect = if_id_valid & ((pc_sel==01 & branch_taken) | pc_sel==11 | pc_sel==10)`.
  - Target is `reg_target` when `pc_sel==10`, otherwise `rel_target`.
- FSM states BOOT, RUN, HALT:
  - BOOT: one cycle after reset release. PC holds RESET_PC, IF/ID stays bubble, then → RUN. This gives one cycle of memory settle after reset.
  - RUN: per edge, highest priority first:
    1. `stall`: PC and IF/ID unchanged. `flush` is ignored while stall is high; the hazard unit re-asserts flush after releasing stall.
    2. `redirect`: PC ← target; IF/ID ← bubble (squashes the wrong-path fetch, 1-cycle penalty).
    3. `flush`: PC ← PC+1; IF/ID ← bubble.
    4. Otherwise: IF/ID ← `{imem_rdata, PC, 1}`; PC ← PC+1.
  - RUN → HALT when `if_id_valid` and `if_id_instr[15:13]==3'b111`, unless a redirect occurs on that edge.
  - HALT: PC frozen; IF/ID ← bubble on the entry edge and held thereafter; `halted=1`. Exit only via `rst_n`.
- PC increment wraps from 2^PC_W−1 to 0; no error is raised.
- Same-edge stall and a HALT opcode in IF/ID: stall wins, and the HALT transition occurs on the first non-stalled edge.
- Reset asserted mid-stall or mid-redirect: everything returns immediately to reset values. No pending redirect survives reset.
- `imem_addr` is combinational from the PC register; the fetch-to-IF/ID latency is 1 cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, the block adds three 16-bit saturating output ports:
  - `perf_fetched`: increments on each edge IF/ID loads a valid instruction.
  - `perf_stall`: increments on each RUN edge with `stall=1`.
  - `perf_squash`: increments on each redirect or flush edge.
- All three reset to 0, hold at 16'hFFFF once reached, and freeze in HALT.
- When not defined, these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset release, memory words 0..3 = 16'hD101, 16'hD202, 16'hA061, 16'hE000 → `imem_addr` 0 in BOOT. IF/ID then shows pc 0,1,2,3 with valid=1 on consecutive cycles. `halted=1` one edge after pc=3 is in IF/ID, PC frozen at 5.
- With `if_id_pc=10` holding a branch with `instr[7:0]=8'hFC`, `pc_sel=01`, `branch_taken=1` → next PC=7, IF/ID bubble for 1 cycle, then the instruction at 7 with valid=1. Same case with `branch_taken=0` → sequential fetch, no bubble.
- BLX with `pc_sel=10`, `reg_target=9'h1F0`, `if_id_pc=4` → `if_id_link=5` while in decode; next PC=0x1F0.
- `stall` high 3 cycles while pc=6 is in IF/ID → `if_id_*` and `imem_addr` unchanged for 3 edges. A simultaneous flush is ignored. Sequential fetch resumes on release.
- PC=9'h1FF, no hazards → next PC=0. `rst_n` pulsed low mid-stall → outputs return to reset values asynchronously, and BOOT is re-entered.
- FETCH_PERF_CNT_EN defined: run the scenario-1 program → `perf_fetched=4`, `perf_squash=0`, all counters frozen after HALT.
